ram_fifo_ctrl: RTL and testbench



---
 rtl/ram_fifo_ctrl_pkg.sv | 22 ++
 rtl/ram_fifo_ctrl_if.sv | 47 ++++
 rtl/fifo_out_stage.sv | 66 ++++++
 rtl/ram_fifo_ctrl.sv | 98 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// rtl/ram_fifo_ctrl_pkg.sv - shared sizing helpers for the RAM-backed stream FIFO
//
// Purpose: derives RAM depth and level width from the RAM address width, so
//          that the interface, the top level and the bench all size from one place.
// Ports:   none (package).

package ram_fifo_ctrl_pkg;

    localparam int DEFAULT_ADDR_SIZE = 7;
    localparam int DEFAULT_DATA_SIZE = 16;

    // RAM depth for a given address width.
    function automatic int depth_of(input int addr_size);
        return 1 << addr_size;
    endfunction

    // The level counts up to DEPTH + 2 (RAM, in-flight read, two output slots).
    function automatic int level_w(input int addr_size);
        return addr_size + 2;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - stream, level and RAM-port bundle of the FIFO controller
//
// Purpose: groups the upstream stream, the downstream stream, the level output
//          and the far-side RAM port of ram_fifo_ctrl.
// Ports (signals):
//   flush                           synchronous clear request
//   in_valid/in_data/in_ready       upstream stream
//   out_valid/out_data/out_ready    downstream stream
//   level                           words held in total
//   ram_wren/ram_waddr/ram_d        RAM write port
//   ram_rden/ram_raddr/ram_q        RAM read port (q valid the cycle after rden)
// Modports: master = the controller, slave = its environment (sources, sink, RAM).

interface ram_fifo_ctrl_if
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
);
    logic                            flush;
    logic                            in_valid;
    logic [DATA_SIZE-1:0]            in_data;
    logic                            in_ready;
    logic                            out_valid;
    logic [DATA_SIZE-1:0]            out_data;
    logic                            out_ready;
    logic [level_w(ADDR_SIZE)-1:0]   level;
    logic                            ram_wren;
    logic [ADDR_SIZE-1:0]            ram_waddr;
    logic [DATA_SIZE-1:0]            ram_d;
    logic                            ram_rden;
    logic [ADDR_SIZE-1:0]            ram_raddr;
    logic [DATA_SIZE-1:0]            ram_q;

    modport master (
        input  flush, in_valid, in_data, out_ready, ram_q,
        output in_ready, out_valid, out_data, level,
               ram_wren, ram_waddr, ram_d, ram_rden, ram_raddr
    );

    modport slave (
        output flush, in_valid, in_data, out_ready, ram_q,
        input  in_ready, out_valid, out_data, level,
               ram_wren, ram_waddr, ram_d, ram_rden, ram_raddr
    );

endinterface

// File: rtl/fifo_out_stage.sv
// rtl/fifo_out_stage.sv - two-entry output stage hiding the RAM read latency
//
// Purpose: captures RAM read data one cycle after a read issue and presents the
//          oldest word on slot0; slot1 holds the next word.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   i_flush        drop everything held, including an arriving read
//   i_rd_pend      a read was issued last cycle, i_ram_q carries its data
//   i_ram_q        RAM read data
//   i_out_ready    downstream takes slot0 when o_out_valid is high
//   o_slot0        oldest word
//   o_stage_cnt    words held (0..2)
//   o_out_valid    slot0 holds a word

module fifo_out_stage #(
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_flush,
    input  logic                 i_rd_pend,
    input  logic [DATA_SIZE-1:0] i_ram_q,
    input  logic                 i_out_ready,
    output logic [DATA_SIZE-1:0] o_slot0,
    output logic [1:0]           o_stage_cnt,
    output logic                 o_out_valid
);

    logic [DATA_SIZE-1:0] r_slot0;
    logic [DATA_SIZE-1:0] r_slot1;
    logic [1:0]           r_stage_cnt;
    logic                 w_pop;
    logic [1:0]           w_cnt_after_pop;

    assign w_pop           = (r_stage_cnt != 2'd0) && i_out_ready;
    assign w_cnt_after_pop = r_stage_cnt - {1'b0, w_pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot0     <= '0;
            r_slot1     <= '0;
            r_stage_cnt <= 2'd0;
        end else if (i_flush) begin
            r_stage_cnt <= 2'd0;
        end else begin
            if (w_pop) begin
                r_slot0 <= r_slot1;
            end
            // Arriving data lands in slot0 only if the stage drains this cycle;
            // this assignment overrides the shift above in that case.
            if (i_rd_pend) begin
                if (w_cnt_after_pop == 2'd0) begin
                    r_slot0 <= i_ram_q;
                end else begin
                    r_slot1 <= i_ram_q;
                end
            end
            r_stage_cnt <= w_cnt_after_pop + {1'b0, i_rd_pend};
        end
    end

    assign o_slot0     = r_slot0;
    assign o_stage_cnt = r_stage_cnt;
    assign o_out_valid = (r_stage_cnt != 2'd0);

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - stream FIFO controller driving a dual-port RAM
//
// Purpose: stores a sample stream in an external dual-port RAM (registered read
//          address, one cycle read latency) with valid/ready on both sides and
//          one word per cycle sustained throughput. Capacity is DEPTH + 2 words.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   bus         ram_fifo_ctrl_if.master: flush, upstream/downstream streams,
//               level and the RAM write/read ports

module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input  logic            clk,
    input  logic            reset,
    ram_fifo_ctrl_if.master bus
);

    localparam int DEPTH = depth_of(ADDR_SIZE);
    localparam int PTR_W = ADDR_SIZE + 1;
    localparam int LVL_W = level_w(ADDR_SIZE);

    // One extra pointer bit distinguishes full from empty.
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic                 r_rd_pend;

    logic [PTR_W-1:0]     w_mem_count;
    logic                 w_full;
    logic                 w_in_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rden;
    logic [2:0]           w_occ_after;
    logic [1:0]           w_stage_cnt;
    logic                 w_out_valid;
    logic [DATA_SIZE-1:0] w_slot0;

    assign w_mem_count = r_wptr - r_rptr;
    assign w_full      = (w_mem_count == PTR_W'(DEPTH));

    assign w_in_ready  = !w_full && !bus.flush && !reset;
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Stage slots still committed after this cycle's pop; a new read may only
    // be issued if its data will have a free slot when it arrives.
    assign w_occ_after = {1'b0, w_stage_cnt} + {2'b0, r_rd_pend} - {2'b0, w_pop};
    assign w_rden      = (w_mem_count != '0) && !bus.flush && (w_occ_after < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rd_pend <= 1'b0;
        end else if (bus.flush) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rden) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_rd_pend <= w_rden;
        end
    end

    fifo_out_stage #(
        .DATA_SIZE (DATA_SIZE)
    ) u_out_stage (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (bus.flush),
        .i_rd_pend   (r_rd_pend),
        .i_ram_q     (bus.ram_q),
        .i_out_ready (bus.out_ready),
        .o_slot0     (w_slot0),
        .o_stage_cnt (w_stage_cnt),
        .o_out_valid (w_out_valid)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.ram_wren  = w_push;
    assign bus.ram_waddr = r_wptr[ADDR_SIZE-1:0];
    assign bus.ram_d     = bus.in_data;
    assign bus.ram_rden  = w_rden;
    assign bus.ram_raddr = r_rptr[ADDR_SIZE-1:0];
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_slot0;
    assign bus.level     = LVL_W'(w_mem_count) + LVL_W'(r_rd_pend) + LVL_W'(w_stage_cnt);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - directed self-checking bench for ram_fifo_ctrl

module tb_ram_fifo_ctrl;

    localparam int AW = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

    ram_fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Dual-port RAM: registered read address, unregistered output.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [AW-1:0] ram_ra = '0;

    always @(posedge clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_waddr] <= bus.ram_d;
        if (bus.ram_rden) ram_ra <= bus.ram_raddr;
    end
    assign bus.ram_q = ram_mem[ram_ra];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n, w, widx, nout, bubbles, lvl_bad, stall;
        logic [15:0] expw;
        logic [15:0] sq[$];
        logic [15:0] front;

        bus.flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 16'h1234;
        bus.out_ready = 1'b1;

        // Reset state, with a word offered during reset.
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_ram_wren", bus.ram_wren, 0);
        check("rst_ram_rden", bus.ram_rden, 0);
        check("rst_level", bus.level, 0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Five words back-to-back, sink always ready: visible 2 cycles after acceptance.
        expw = 16'h0001;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = (k < 5);
            bus.in_data = 16'(k + 1);
            bus.out_ready = 1'b1;
            #1;
            if (k == 0) begin
                check("t1_wren", bus.ram_wren, 1);
                check("t1_waddr", bus.ram_waddr, 0);
                check("t1_d", bus.ram_d, 16'h0001);
            end
            check($sformatf("t1_out_valid_c%0d", k), bus.out_valid, (k >= 3 && k <= 7));
            if (bus.out_valid) begin
                check("t1_data", bus.out_data, expw);
                expw++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        check("t1_count", expw, 16'h0006);
        check("t1_level_end", bus.level, 0);
        tick();

        // Fill with the sink stalled: DEPTH + 2 = 10 words.
        acc = 0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 14; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 16'(16'h0100 + acc);
            #1;
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b1;
        #1;
        check("t2_accepted", acc, 10);
        check("t2_level_full", bus.level, 10);
        check("t2_in_ready_full", bus.in_ready, 0);
        check("t2_wren_full", bus.ram_wren, 0);
        check("t2_rden_full", bus.ram_rden, 0);
        check("t2_out_valid", bus.out_valid, 1);
        check("t2_head", bus.out_data, 16'h0100);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("t2_pop_rden", bus.ram_rden, 1);
        check("t2_pop_in_ready", bus.in_ready, 0);
        tick();
        bus.out_ready = 1'b0;
        #1;
        check("t2_in_ready_after", bus.in_ready, 1);
        check("t2_level_after", bus.level, 9);
        check("t2_head_after", bus.out_data, 16'h0101);
        tick();
        n = 0;
        expw = 16'h0101;
        for (int k = 0; k < 20; k++) begin
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                check("t2_drain_data", bus.out_data, expw);
                expw++;
                n++;
            end
            tick();
        end
        check("t2_drain_count", n, 9);
        check("t2_level_empty", bus.level, 0);
        check("t2_out_valid_empty", bus.out_valid, 0);

        // 200 words streamed with both sides always ready.
        widx = 0; nout = 0; bubbles = 0; lvl_bad = 0; stall = 0;
        for (int k = 0; k < 210; k++) begin
            bus.in_valid = (widx < 200);
            bus.in_data = 16'(widx * 16'h9E37 + 5);
            bus.out_ready = 1'b1;
            #1;
            if (k >= 3 && k <= 202 && !bus.out_valid) bubbles++;
            if (k >= 3 && k <= 200 && bus.level != 3) lvl_bad++;
            if (bus.out_valid) begin
                check("t3_data", bus.out_data, 16'(nout * 16'h9E37 + 5));
                nout++;
            end
            if (bus.in_valid && bus.in_ready) widx++;
            else if (bus.in_valid) stall++;
            tick();
        end
        check("t3_pushed", widx, 200);
        check("t3_popped", nout, 200);
        check("t3_bubbles", bubbles, 0);
        check("t3_level_steady", lvl_bad, 0);
        check("t3_in_stalls", stall, 0);

        // Flush with a read in flight and one word in the stage.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 16'(16'h0A00 + k);
            #1;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data = 16'hDEAD;
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        #1;
        check("t4_level_pre", bus.level, 3);
        check("t4_out_valid_pre", bus.out_valid, 1);
        check("t4_flush_in_ready", bus.in_ready, 0);
        check("t4_flush_wren", bus.ram_wren, 0);
        check("t4_flush_rden", bus.ram_rden, 0);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hBEEF;
        bus.out_ready = 1'b0;
        #1;
        check("t4_out_valid_post", bus.out_valid, 0);
        check("t4_level_post", bus.level, 0);
        check("t4_in_ready_post", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        w = 0;
        while (!bus.out_valid && w < 10) begin
            tick();
            #1;
            w++;
        end
        check("t4_latency", w, 2);
        check("t4_first_word", bus.out_data, 16'hBEEF);
        tick();
        #1;
        check("t4_empty_after", bus.level, 0);
        check("t4_no_stale", bus.out_valid, 0);
        tick();

        // Asynchronous reset in the middle of a stream.
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 16'(16'h0C00 + k);
            bus.out_ready = 1'b1;
            #1;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data = 16'h0C06;
        #1;
        check("t5_rden_pre", bus.ram_rden, 1);
        check("t5_level_pre", bus.level, 3);
        reset = 1'b1;
        #1;
        check("t5_out_valid", bus.out_valid, 0);
        check("t5_in_ready", bus.in_ready, 0);
        check("t5_wren", bus.ram_wren, 0);
        check("t5_rden", bus.ram_rden, 0);
        check("t5_level", bus.level, 0);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data = 16'h0055;
        bus.out_ready = 1'b0;
        #1;
        check("t5_in_ready_after", bus.in_ready, 1);
        check("t5_waddr_after", bus.ram_waddr, 0);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        w = 0;
        while (!bus.out_valid && w < 10) begin
            tick();
            #1;
            w++;
        end
        check("t5_latency", w, 2);
        check("t5_first_word", bus.out_data, 16'h0055);
        tick();
        #1;
        check("t5_empty_after", bus.level, 0);
        tick();

        // Random valid/ready against a queue scoreboard, with fill and drain phases.
        for (int k = 0; k < 2000; k++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data = 16'($urandom);
            bus.out_ready = ((k % 400) < 200) ? ($urandom_range(0, 3) == 0)
                                              : ($urandom_range(0, 3) != 0);
            #1;
            check("t6_level", bus.level, sq.size());
            if (bus.ram_rden && bus.ram_wren)
                check("t6_addr_clash", bus.ram_raddr != bus.ram_waddr, 1);
            if (bus.out_valid && bus.out_ready) begin
                check("t6_nonempty", sq.size() != 0, 1);
                if (sq.size() != 0) begin
                    front = sq.pop_front();
                    check("t6_data", bus.out_data, front);
                end
            end
            if (bus.in_valid && bus.in_ready) sq.push_back(bus.in_data);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                check("t6_drain_nonempty", sq.size() != 0, 1);
                if (sq.size() != 0) begin
                    front = sq.pop_front();
                    check("t6_drain_data", bus.out_data, front);
                end
            end
            tick();
        end
        check("t6_all_delivered", sq.size(), 0);
        check("t6_level_end", bus.level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
